eth_recv: RTL and testbench
===========================

ETH_RECV -- requirements
Module: eth_recv

Interface
REQ-001 SHALL have parameter UDP_PORT, default 16'd3776, the UDP destination port accepted.
REQ-002 SHALL have parameter CHECK_BCAST, default 1'b1; when 1, dst MAC ff:ff:ff:ff:ff:ff is also accepted.
REQ-003 SHALL have port clk156  in  1  the single clock for all logic.
REQ-004 SHALL have port aresetn  in  1  reset, synchronous and active-low, sampled only on the rising edge of clk156.
REQ-005 SHALL have port local_mac  in  48  station MAC; byte 0 (first on wire) is in [47:40].
REQ-006 SHALL have input ports s_axis_rx_tvalid/tdata[63:0]/tkeep[7:0]/tlast/tuser (1/64/8/1/1), the MAC receive stream.
- No tready: the MAC cannot be stalled.
- Wire byte n of a beat is in tdata[8n+7:8n].
- tuser=1 on the last beat marks a bad frame.
REQ-007 SHALL have output ports m_axis_tvalid/tdata[63:0]/tkeep[7:0]/tlast/tuser (1/64/8/1/1) and input m_axis_tready, carrying the UDP payload.
REQ-008 SHALL have outputs rx_frames, rx_drops, rx_overflows, each 32 bits, counting accepted, filtered and overflowed frames.

Function
REQ-009 SHALL track header beats 0..4 with a 3-bit beat counter and use states HDR, PAYLOAD, DROP.
REQ-010 SHALL accept a frame only if all hold: dst MAC (bytes 0-5) = local_mac or broadcast; ethertype (bytes 12-13) = 0x0800; byte 14 = 0x45; protocol (byte 23) = 17; dst port (bytes 36-37) = UDP_PORT.
REQ-011 SHALL make the accept decision on the cycle beat 4 is received: HDR->PAYLOAD if accepted, else HDR->DROP.
REQ-012 SHALL treat a frame with tlast before beat 5 as a drop and count it in rx_drops.
REQ-013 SHALL strip the 42-byte header and start payload at wire byte 42 (beat 5, lane 2).
REQ-014 SHALL realign payload so each output beat = lanes 2-7 of input beat n in out lanes 0-5, plus lanes 0-1 of beat n+1 in out lanes 6-7.
- Latency is one input beat.
- tkeep is contiguous from lane 0.
REQ-015 SHALL end the frame as follows when the last input beat has at most 2 valid bytes:
- Those bytes complete the previous output beat, which carries tlast=1.
- No extra output beat is issued.
- A last beat of 0 payload bytes is legal.
REQ-016 SHALL drive m_axis_tuser on the tlast beat only, equal to the input tuser of the frame's last beat.
REQ-017 SHALL hold an output beat stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 SHALL handle overflow (a new output beat is due while the held beat is still unaccepted) as follows:
- Force tlast=1 and tuser=1 on the held beat.
- Discard the rest of the frame in DROP.
- Increment rx_overflows.
REQ-019 SHALL, in DROP, ignore input until tlast and then return to HDR.
REQ-020 SHALL handle simultaneous events within one cycle:
- A frame's tlast and the next frame's beat 0 never coincide.
- Output-accept and new-beat in the same cycle is not overflow.
REQ-021 SHALL saturate the counters at 32'hFFFF_FFFF.
REQ-022 SHALL increment rx_frames on emission of the output tlast beat without forced tuser.

Reset
REQ-023 SHALL, while aresetn=0 at a clk156 edge, set state=HDR, beat counter=0, m_axis_tvalid=0, tlast=0, tuser=0, tkeep=0, tdata=0 and all counters=0.
REQ-024 SHALL discard a frame interrupted by reset, with no partial output, and process the next s_axis beat after reset release as beat 0.

Configuration
REQ-025 SHALL compile the three counters only with ETH_RECV_STATS_EN defined; without the macro the counter outputs are tied to 32'd0 and no counter flops exist.

Structure
REQ-026 SHALL place in shared package eth_pkg: ETHTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, HDR_BYTES=42, and enum rx_state_t {HDR, PAYLOAD, DROP}.
REQ-027 SHALL implement realignment and output holding in sub-module eth_recv_align; filtering, FSM and counters are in eth_recv.

Verification
REQ-028 SHALL cover: UDP to local_mac with port 3776 and a 16-byte payload -> 2 output beats (tkeep ff, ff), tlast on beat 2, rx_frames=1.
REQ-029 SHALL cover: UDP frame with port 3777 -> no m_axis_tvalid, rx_drops=1.
REQ-030 SHALL cover: broadcast dst, 1-byte payload, last input beat tkeep=8'h07 -> single output beat tkeep=8'h01, tlast=1.
REQ-031 SHALL cover: MAC tuser=1 on the last beat of an accepted frame -> output tlast beat tuser=1, rx_frames unchanged.
REQ-032 SHALL cover: m_axis_tready=0 throughout a 64-byte payload -> first beat held with tlast=1 and tuser=1, rx_overflows=1, the next frame is received correctly.
REQ-033 SHALL cover: aresetn low during beat 6 of a frame -> outputs zero next cycle, the frame after release is parsed correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, state type and keep-mask helper for the UDP receive path
package eth_pkg;
    localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam int          HDR_BYTES    = 42;
    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} rx_state_t;
    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        return 8'hff >> (4'd8 - n);
    endfunction
endpackage

// File: rtl/eth_recv_align.sv
// eth_recv_align: shifts payload from lane 2 to lane 0 and holds the output beat
//   clk156/aresetn : clock, sync active-low reset
//   in_*           : payload-phase input beats (beat 5 onward)
//   m_axis_*       : realigned payload stream
//   ovf            : new beat due while held beat unaccepted
//   frame_ok       : clean tlast beat loaded this cycle
module eth_recv_align import eth_pkg::*; (
    input  logic        clk156,
    input  logic        aresetn,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_keep,
    input  logic        in_last,
    input  logic        in_user,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic        ovf,
    output logic        frame_ok
);
    logic [47:0] prev;
    logic        have_prev, flush, flush_user, load, ld_last, ld_user;
    logic [3:0]  flush_cnt, cnt;
    logic [63:0] ld_data;
    logic [7:0]  ld_keep;
    // flush emits the tail of a last beat holding more than two bytes
    always_comb begin
        cnt      = 4'($countones(in_keep));
        load     = flush || (in_valid && (have_prev || in_last));
        ld_data  = flush ? {16'h0, prev} : have_prev ? {in_data[15:0], prev} : {16'h0, in_data[63:16]};
        ld_keep  = flush ? keep_mask(flush_cnt) :
                   have_prev ? keep_mask(cnt > 4'd2 ? 4'd8 : cnt + 4'd6) :
                   keep_mask(cnt > 4'd2 ? cnt - 4'd2 : 4'd0);
        ld_last  = flush || (in_last && (!have_prev || cnt <= 4'd2));
        ld_user  = flush ? flush_user : in_user && ld_last;
        ovf      = load && m_axis_tvalid && !m_axis_tready;
        frame_ok = load && !ovf && ld_last && !ld_user;
    end
    always_ff @(posedge clk156) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            prev          <= '0;
            have_prev     <= 1'b0;
            flush         <= 1'b0;
            flush_cnt     <= '0;
            flush_user    <= 1'b0;
        end else if (ovf) begin
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= 1'b1;
            have_prev    <= 1'b0;
            flush        <= 1'b0;
        end else begin
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= ld_data;
                m_axis_tkeep  <= ld_keep;
                m_axis_tlast  <= ld_last;
                m_axis_tuser  <= ld_user;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            flush      <= in_valid && in_last && have_prev && cnt > 4'd2;
            flush_cnt  <= cnt - 4'd2;
            flush_user <= in_user;
            if (in_valid) begin
                prev      <= in_data[63:16];
                have_prev <= !in_last;
            end
        end
    end
endmodule

// File: rtl/eth_recv.sv
// eth_recv: filters IPv4/UDP frames to local_mac:UDP_PORT and emits the realigned payload
//   clk156/aresetn : clock, sync active-low reset
//   local_mac      : station MAC, first wire byte in [47:40]
//   s_axis_rx_*    : MAC receive stream (no backpressure)
//   m_axis_*       : UDP payload stream
//   rx_*           : frame/drop/overflow counters, present only with ETH_RECV_STATS_EN
module eth_recv import eth_pkg::*; #(
    parameter logic [15:0] UDP_PORT    = 16'd3776,
    parameter bit          CHECK_BCAST = 1'b1
) (
    input  logic        clk156,
    input  logic        aresetn,
    input  logic [47:0] local_mac,
    input  logic        s_axis_rx_tvalid,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [31:0] rx_frames,
    output logic [31:0] rx_drops,
    output logic [31:0] rx_overflows
);
    rx_state_t   state;
    logic [2:0]  bcnt;
    logic        ok, hit, acc, ovf, frame_ok;
    logic [47:0] dst;
    logic [63:0] d;
    always_comb begin
        d   = s_axis_rx_tdata;
        dst = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
        hit = bcnt == 3'd0 ? (dst == local_mac || (CHECK_BCAST && dst == '1)) :
              bcnt == 3'd1 ? ({d[39:32], d[47:40]} == ETHTYPE_IPV4 && d[55:48] == 8'h45) :
              bcnt == 3'd2 ? d[63:56] == IP_PROTO_UDP :
              bcnt == 3'd3 ? 1'b1 :
              {d[39:32], d[47:40]} == UDP_PORT;
        acc = (bcnt == 3'd0 || ok) && hit;
    end
    always_ff @(posedge clk156) begin
        if (!aresetn) begin
            state <= HDR;
            bcnt  <= '0;
            ok    <= 1'b0;
        end else if (state == HDR) begin
            if (s_axis_rx_tvalid) begin
                ok   <= acc;
                bcnt <= (s_axis_rx_tlast || bcnt == 3'd4) ? 3'd0 : bcnt + 3'd1;
                if (!s_axis_rx_tlast && bcnt == 3'd4)
                    state <= acc ? PAYLOAD : DROP;
            end
        end else if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
            state <= HDR;
        end else if (state == PAYLOAD && ovf) begin
            state <= DROP;
        end
    end
    eth_recv_align u_align (
        .clk156        (clk156),
        .aresetn       (aresetn),
        .in_valid      (s_axis_rx_tvalid && state == PAYLOAD),
        .in_data       (s_axis_rx_tdata),
        .in_keep       (s_axis_rx_tkeep),
        .in_last       (s_axis_rx_tlast),
        .in_user       (s_axis_rx_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .ovf           (ovf),
        .frame_ok      (frame_ok)
    );
`ifdef ETH_RECV_STATS_EN
    // a drop is a header-phase tlast or a beat-4 rejection
    always_ff @(posedge clk156) begin
        if (!aresetn) begin
            rx_frames    <= '0;
            rx_drops     <= '0;
            rx_overflows <= '0;
        end else begin
            if (frame_ok && rx_frames != '1)
                rx_frames <= rx_frames + 32'd1;
            if (ovf && rx_overflows != '1)
                rx_overflows <= rx_overflows + 32'd1;
            if (state == HDR && s_axis_rx_tvalid && (s_axis_rx_tlast || (bcnt == 3'd4 && !acc)) && rx_drops != '1)
                rx_drops <= rx_drops + 32'd1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok    = frame_ok;
    assign rx_frames    = 32'd0;
    assign rx_drops     = 32'd0;
    assign rx_overflows = 32'd0;
`endif
endmodule

// File: tb/tb_eth_recv.sv
// tb_eth_recv: table-driven frame vectors plus overflow and reset sequences for eth_recv
module tb_eth_recv;
    localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;
`ifdef ETH_RECV_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic        clk156 = 1'b0;
    logic        aresetn;
    logic        s_axis_rx_tvalid, s_axis_rx_tlast, s_axis_rx_tuser;
    logic [63:0] s_axis_rx_tdata;
    logic [7:0]  s_axis_rx_tkeep;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [31:0] rx_frames, rx_drops, rx_overflows;
    always #5 clk156 = ~clk156;
    eth_recv dut (
        .clk156           (clk156),
        .aresetn          (aresetn),
        .local_mac        (MAC),
        .s_axis_rx_tvalid (s_axis_rx_tvalid),
        .s_axis_rx_tdata  (s_axis_rx_tdata),
        .s_axis_rx_tkeep  (s_axis_rx_tkeep),
        .s_axis_rx_tlast  (s_axis_rx_tlast),
        .s_axis_rx_tuser  (s_axis_rx_tuser),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tready    (m_axis_tready),
        .rx_frames        (rx_frames),
        .rx_drops         (rx_drops),
        .rx_overflows     (rx_overflows)
    );
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;
    typedef struct {
        int          mac_sel;
        logic [15:0] et;
        logic [7:0]  ver;
        logic [7:0]  proto;
        logic [15:0] port;
        int          tot;
        bit          bad;
        int          beats;
        logic [7:0]  lkeep;
        bit          luser;
        int          dfr;
        int          ddr;
    } vec_t;
    beat_t      q[$];
    vec_t       vecs[15];
    int         checks = 0, errors = 0;
    int         exp_fr = 0, exp_dr = 0, exp_ov = 0;
    logic [7:0] fb[0:127];
    always @(negedge clk156) begin
        beat_t b;
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            b.data = m_axis_tdata;
            b.keep = m_axis_tkeep;
            b.last = m_axis_tlast;
            b.user = m_axis_tuser;
            q.push_back(b);
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk156);
        #1;
    endtask
    task automatic build(input int mac_sel, input logic [15:0] et, input logic [7:0] ver,
                         input logic [7:0] proto, input logic [15:0] port, input int seed);
        logic [47:0] dm;
        dm = mac_sel == 0 ? MAC : mac_sel == 1 ? 48'hffff_ffff_ffff : 48'h02_11_22_33_44_56;
        for (int i = 0; i < 128; i++) fb[i] = 8'(i * 7 + seed * 13 + 1);
        for (int i = 0; i < 6; i++) fb[i] = dm[47 - 8 * i -: 8];
        fb[12] = et[15:8];
        fb[13] = et[7:0];
        fb[14] = ver;
        fb[23] = proto;
        fb[36] = port[15:8];
        fb[37] = port[7:0];
    endtask
    task automatic drive_beat(input int b, input int tot, input bit bad);
        int n;
        n = tot - 8 * b;
        s_axis_rx_tvalid = 1'b1;
        for (int l = 0; l < 8; l++) begin
            s_axis_rx_tdata[8 * l +: 8] = l < n ? fb[8 * b + l] : 8'h00;
            s_axis_rx_tkeep[l] = l < n;
        end
        s_axis_rx_tlast = n <= 8;
        s_axis_rx_tuser = bad && n <= 8;
        tick();
    endtask
    task automatic idle(input int n);
        s_axis_rx_tvalid = 1'b0;
        s_axis_rx_tlast  = 1'b0;
        s_axis_rx_tuser  = 1'b0;
        repeat (n) tick();
    endtask
    task automatic send(input int tot, input bit bad);
        for (int b = 0; b * 8 < tot; b++) drive_beat(b, tot, bad);
        idle(4);
    endtask
    task automatic check_out(input string name, input int tot, input int beats,
                             input logic [7:0] lkeep, input logic luser);
        int k, lastpos;
        bit good;
        k = 0;
        lastpos = -1;
        good = 1'b1;
        chk({name, " beats"}, 64'(q.size()), 64'(beats));
        foreach (q[i]) begin
            if (q[i].last && lastpos < 0) lastpos = i;
            if (!q[i].last && q[i].user) good = 1'b0;
            for (int l = 0; l < 8; l++) begin
                if (q[i].keep[l]) begin
                    if (k >= tot - 42 || q[i].data[8 * l +: 8] !== fb[42 + k]) good = 1'b0;
                    k++;
                end
            end
        end
        if (q.size() > 0) begin
            chk({name, " last tkeep"}, 64'(q[q.size() - 1].keep), 64'(lkeep));
            chk({name, " last tuser"}, 64'(q[q.size() - 1].user), 64'(luser));
            chk({name, " tlast position"}, 64'(lastpos), 64'(q.size() - 1));
        end
        if (beats > 0) chk({name, " payload bytes"}, 64'(good && k == tot - 42), 64'd1);
        q.delete();
    endtask
    task automatic chk_cnt(input string name);
        chk({name, " rx_frames"}, 64'(rx_frames), STATS ? 64'(exp_fr) : 64'd0);
        chk({name, " rx_drops"}, 64'(rx_drops), STATS ? 64'(exp_dr) : 64'd0);
        chk({name, " rx_overflows"}, 64'(rx_overflows), STATS ? 64'(exp_ov) : 64'd0);
    endtask
    initial begin
        logic [63:0] held;
        vecs[0]  = '{0, 16'h0800, 8'h45, 8'd17, 16'd3776, 58, 1'b0, 2, 8'hff, 1'b0, 1, 0};
        vecs[1]  = '{0, 16'h0800, 8'h45, 8'd17, 16'd3777, 58, 1'b0, 0, 8'h00, 1'b0, 0, 1};
        vecs[2]  = '{1, 16'h0800, 8'h45, 8'd17, 16'd3776, 43, 1'b0, 1, 8'h01, 1'b0, 1, 0};
        vecs[3]  = '{0, 16'h0800, 8'h45, 8'd17, 16'd3776, 58, 1'b1, 2, 8'hff, 1'b1, 0, 0};
        vecs[4]  = '{0, 16'h86dd, 8'h45, 8'd17, 16'd3776, 58, 1'b0, 0, 8'h00, 1'b0, 0, 1};
        vecs[5]  = '{0, 16'h0800, 8'h46, 8'd17, 16'd3776, 58, 1'b0, 0, 8'h00, 1'b0, 0, 1};
        vecs[6]  = '{0, 16'h0800, 8'h45, 8'd6,  16'd3776, 58, 1'b0, 0, 8'h00, 1'b0, 0, 1};
        vecs[7]  = '{2, 16'h0800, 8'h45, 8'd17, 16'd3776, 58, 1'b0, 0, 8'h00, 1'b0, 0, 1};
        vecs[8]  = '{0, 16'h0800, 8'h45, 8'd17, 16'd3776, 30, 1'b0, 0, 8'h00, 1'b0, 0, 1};
        vecs[9]  = '{0, 16'h0800, 8'h45, 8'd17, 16'd3776, 40, 1'b0, 0, 8'h00, 1'b0, 0, 1};
        vecs[10] = '{0, 16'h0800, 8'h45, 8'd17, 16'd3776, 48, 1'b0, 1, 8'h3f, 1'b0, 1, 0};
        vecs[11] = '{1, 16'h0800, 8'h45, 8'd17, 16'd3776, 50, 1'b0, 1, 8'hff, 1'b0, 1, 0};
        vecs[12] = '{0, 16'h0800, 8'h45, 8'd17, 16'd3776, 51, 1'b0, 2, 8'h01, 1'b0, 1, 0};
        vecs[13] = '{0, 16'h0800, 8'h45, 8'd17, 16'd3776, 56, 1'b0, 2, 8'h3f, 1'b0, 1, 0};
        vecs[14] = '{1, 16'h0800, 8'h45, 8'd17, 16'd3776, 60, 1'b0, 3, 8'h03, 1'b0, 1, 0};
        aresetn = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_rx_tdata = '0;
        s_axis_rx_tkeep = '0;
        idle(3);
        chk("reset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset tdata", m_axis_tdata, 64'd0);
        chk("reset tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("reset tlast", 64'(m_axis_tlast), 64'd0);
        chk("reset tuser", 64'(m_axis_tuser), 64'd0);
        chk_cnt("reset");
        aresetn = 1'b1;
        idle(1);
        for (int i = 0; i < 15; i++) begin
            build(vecs[i].mac_sel, vecs[i].et, vecs[i].ver, vecs[i].proto, vecs[i].port, i);
            send(vecs[i].tot, vecs[i].bad);
            exp_fr += vecs[i].dfr;
            exp_dr += vecs[i].ddr;
            check_out($sformatf("vec%0d", i), vecs[i].tot, vecs[i].beats, vecs[i].lkeep, vecs[i].luser);
            chk_cnt($sformatf("vec%0d", i));
        end
        m_axis_tready = 1'b0;
        build(0, 16'h0800, 8'h45, 8'd17, 16'd3776, 40);
        send(106, 1'b0);
        exp_ov++;
        for (int l = 0; l < 8; l++) held[8 * l +: 8] = fb[42 + l];
        chk("ovf held tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("ovf held tlast", 64'(m_axis_tlast), 64'd1);
        chk("ovf held tuser", 64'(m_axis_tuser), 64'd1);
        chk("ovf held tkeep", 64'(m_axis_tkeep), 64'hff);
        chk("ovf held tdata", m_axis_tdata, held);
        chk_cnt("ovf");
        m_axis_tready = 1'b1;
        idle(2);
        chk("ovf drained beats", 64'(q.size()), 64'd1);
        q.delete();
        build(0, 16'h0800, 8'h45, 8'd17, 16'd3776, 41);
        send(58, 1'b0);
        exp_fr++;
        check_out("after ovf", 58, 2, 8'hff, 1'b0);
        chk_cnt("after ovf");
        m_axis_tready = 1'b0;
        build(0, 16'h0800, 8'h45, 8'd17, 16'd3776, 50);
        for (int b = 0; b < 6; b++) drive_beat(b, 106, 1'b0);
        aresetn = 1'b0;
        drive_beat(6, 106, 1'b0);
        chk("rst tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst tdata", m_axis_tdata, 64'd0);
        chk("rst tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst tlast", 64'(m_axis_tlast), 64'd0);
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        exp_fr = 0;
        exp_dr = 0;
        exp_ov = 0;
        idle(1);
        chk_cnt("rst");
        q.delete();
        build(1, 16'h0800, 8'h45, 8'd17, 16'd3776, 51);
        send(58, 1'b0);
        exp_fr++;
        check_out("after rst", 58, 2, 8'hff, 1'b0);
        chk_cnt("after rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
